blocking_cache_wb_ctrl: RTL and testbench

- Control unit for a parametrised, direct-mapped, write-back, write-allocate blocking cache.
- Pairs with the existing blocking-cache datapath: drives all enables and mux selects, and owns the valid and dirty bit arrays.
- Handles init, read and write hits, clean misses (refill only) and dirty misses (evict then refill).
- Sits between the processor-side cache port and the memory-side full-line port.

---
 rtl/blocking_cache_wb_ctrl_pkg.sv | 35 +++
 rtl/blocking_cache_wb_ctrl_if.sv | 31 +++
 rtl/blocking_cache_wb_ctrl_meta_bits.sv | 37 +++
 rtl/blocking_cache_wb_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_blocking_cache_wb_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/blocking_cache_wb_ctrl_pkg.sv
// Shared types and encodings for the write-back blocking cache controller.
// State machine states, request/memory type codes and datapath mux select values.
package blocking_cache_wb_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    TAG_CHECK,
    INIT_ACCESS,
    READ_ACCESS,
    WRITE_ACCESS,
    EVICT_PREPARE,
    EVICT_REQUEST,
    EVICT_WAIT,
    REFILL_REQUEST,
    REFILL_WAIT,
    REFILL_UPDATE,
    WAIT
  } state_t;

  localparam logic [2:0] TYPE_READ  = 3'd0;
  localparam logic [2:0] TYPE_WRITE = 3'd1;
  localparam logic [2:0] TYPE_INIT  = 3'd2;

  localparam logic [2:0] MEMREQ_READ  = 3'd0;
  localparam logic [2:0] MEMREQ_WRITE = 3'd1;

  // write_data_mux_sel values
  localparam logic REQ_WORD = 1'b0;
  localparam logic MEM_LINE = 1'b1;

  // memreq_addr_mux_sel values
  localparam logic EVICT_ADDR = 1'b0;
  localparam logic REQ_ADDR   = 1'b1;

endpackage

// File: rtl/blocking_cache_wb_ctrl_if.sv
// Processor-side and memory-side handshake bundle of the cache controller.
// slave = the controller's view, master = the surrounding processor/memory environment.
interface blocking_cache_wb_ctrl_if;

  logic        cachereq_val;
  logic        cachereq_rdy;
  logic [2:0]  cachereq_type;
  logic [31:0] cachereq_addr;

  logic        cacheresp_val;
  logic        cacheresp_rdy;
  logic [2:0]  cacheresp_type;

  logic        memreq_val;
  logic        memreq_rdy;
  logic [2:0]  memreq_type;

  logic        memresp_val;
  logic        memresp_rdy;

  modport slave (
    input  cachereq_val, cachereq_type, cachereq_addr, cacheresp_rdy, memreq_rdy, memresp_val,
    output cachereq_rdy, cacheresp_val, cacheresp_type, memreq_val, memreq_type, memresp_rdy
  );

  modport master (
    output cachereq_val, cachereq_type, cachereq_addr, cacheresp_rdy, memreq_rdy, memresp_val,
    input  cachereq_rdy, cacheresp_val, cacheresp_type, memreq_val, memreq_type, memresp_rdy
  );

endinterface

// File: rtl/blocking_cache_wb_ctrl_meta_bits.sv
// Per-line valid and dirty bits: one combinational read port and one write port
// sharing the same index, with independent valid/dirty write enables.
module blocking_cache_wb_ctrl_meta_bits #(
  parameter  int p_num_blocks = 16,
  localparam int idw          = $clog2(p_num_blocks)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [idw-1:0] idx,
  output logic           rd_valid,
  output logic           rd_dirty,
  input  logic           valid_wen,
  input  logic           valid_wdata,
  input  logic           dirty_wen,
  input  logic           dirty_wdata
);

  logic [p_num_blocks-1:0] valid_q;
  logic [p_num_blocks-1:0] dirty_q;

  // NOTE: these bits are flops rather than SRAM, so they are reset; clearing
  // every valid bit is what invalidates the whole cache on reset.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (valid_wen) valid_q[idx] <= valid_wdata;
      if (dirty_wen) dirty_q[idx] <= dirty_wdata;
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];

endmodule

// File: rtl/blocking_cache_wb_ctrl.sv
// Control unit of a direct-mapped, write-back, write-allocate blocking cache.
// Moore FSM driving every datapath enable and mux select; owns the valid/dirty bits.
module blocking_cache_wb_ctrl
  import blocking_cache_wb_ctrl_pkg::*;
#(
  parameter  int p_num_blocks = 16,
  parameter  int p_line_words = 4,
  parameter  int p_idx_shamt  = 0,
  localparam int idw          = $clog2(p_num_blocks),
  localparam int ow           = $clog2(p_line_words)
) (
  input  logic                      clk,
  input  logic                      reset,
  blocking_cache_wb_ctrl_if.slave   bus,
  input  logic                      tag_match,
  output logic                      cachereq_en,
  output logic                      memresp_en,
  output logic                      evict_addr_reg_en,
  output logic                      read_data_reg_en,
  output logic                      tag_array_ren,
  output logic                      tag_array_wen,
  output logic                      data_array_ren,
  output logic                      data_array_wen,
  output logic [4*p_line_words-1:0] data_array_wben,
  output logic                      write_data_mux_sel,
  output logic                      memreq_addr_mux_sel,
  output logic [ow:0]               read_word_mux_sel
);

  localparam int off = ow + 2;

  state_t   state_q, state_n;
  logic [2:0] type_q;

  logic [idw-1:0] idx;
  logic [ow-1:0]  word_off;
  logic           unused_addr_bits;
  logic           valid, dirty, hit;
  logic           valid_wen, valid_wdata, dirty_wen, dirty_wdata;

  logic [4*p_line_words-1:0] word_wben;
  logic [ow:0]               word_sel;
  logic                      resp_has_data;

  assign idx              = bus.cachereq_addr[off+p_idx_shamt+idw-1 -: idw];
  assign word_off         = bus.cachereq_addr[off-1:2];
  assign unused_addr_bits = ^bus.cachereq_addr;

  assign word_wben     = (4*p_line_words)'(4'hF) << {word_off, 2'b00};
  assign word_sel      = (ow+1)'(word_off) + (ow+1)'(1);
  assign resp_has_data = (type_q != TYPE_WRITE) && (type_q != TYPE_INIT);
  assign hit           = tag_match & valid;

  blocking_cache_wb_ctrl_meta_bits #(.p_num_blocks(p_num_blocks)) u_meta (
    .clk         (clk),
    .reset       (reset),
    .idx         (idx),
    .rd_valid    (valid),
    .rd_dirty    (dirty),
    .valid_wen   (valid_wen),
    .valid_wdata (valid_wdata),
    .dirty_wen   (dirty_wen),
    .dirty_wdata (dirty_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      type_q  <= TYPE_READ;
    end else begin
      state_q <= state_n;
      if (state_q == TAG_CHECK) type_q <= bus.cachereq_type;
    end
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_n             = state_q;
    bus.cachereq_rdy    = 1'b0;
    bus.cacheresp_val   = 1'b0;
    bus.cacheresp_type  = 3'd0;
    bus.memreq_val      = 1'b0;
    bus.memreq_type     = MEMREQ_READ;
    bus.memresp_rdy     = 1'b0;
    cachereq_en         = 1'b0;
    memresp_en          = 1'b0;
    evict_addr_reg_en   = 1'b0;
    read_data_reg_en    = 1'b0;
    tag_array_ren       = 1'b0;
    tag_array_wen       = 1'b0;
    data_array_ren      = 1'b0;
    data_array_wen      = 1'b0;
    data_array_wben     = '0;
    write_data_mux_sel  = REQ_WORD;
    memreq_addr_mux_sel = EVICT_ADDR;
    read_word_mux_sel   = '0;
    valid_wen           = 1'b0;
    valid_wdata         = 1'b0;
    dirty_wen           = 1'b0;
    dirty_wdata         = 1'b0;

    case (state_q)
      IDLE: begin
        bus.cachereq_rdy = 1'b1;
        cachereq_en      = 1'b1;
        if (bus.cachereq_val) state_n = TAG_CHECK;
      end
      TAG_CHECK: begin
        tag_array_ren = 1'b1;
        if (bus.cachereq_type == TYPE_INIT)  state_n = INIT_ACCESS;
        else if (hit)                        state_n = (bus.cachereq_type == TYPE_WRITE)
                                                       ? WRITE_ACCESS : READ_ACCESS;
        else if (valid && dirty)             state_n = EVICT_PREPARE;
        else                                 state_n = REFILL_REQUEST;
      end
      INIT_ACCESS: begin
        tag_array_wen   = 1'b1;
        data_array_wen  = 1'b1;
        data_array_wben = word_wben;
        valid_wen       = 1'b1;
        valid_wdata     = 1'b1;
        dirty_wen       = 1'b1;
        state_n         = WAIT;
      end
      READ_ACCESS: begin
        data_array_ren    = 1'b1;
        read_data_reg_en  = 1'b1;
        read_word_mux_sel = word_sel;
        state_n           = WAIT;
      end
      WRITE_ACCESS: begin
        data_array_wen  = 1'b1;
        data_array_wben = word_wben;
        dirty_wen       = 1'b1;
        dirty_wdata     = 1'b1;
        state_n         = WAIT;
      end
      EVICT_PREPARE: begin
        tag_array_ren     = 1'b1;
        data_array_ren    = 1'b1;
        evict_addr_reg_en = 1'b1;
        read_data_reg_en  = 1'b1;
        state_n           = EVICT_REQUEST;
      end
      EVICT_REQUEST: begin
        bus.memreq_val  = 1'b1;
        bus.memreq_type = MEMREQ_WRITE;
        if (bus.memreq_rdy) state_n = EVICT_WAIT;
      end
      EVICT_WAIT: begin
        bus.memresp_rdy = 1'b1;
        if (bus.memresp_val) state_n = REFILL_REQUEST;
      end
      REFILL_REQUEST: begin
        bus.memreq_val      = 1'b1;
        memreq_addr_mux_sel = REQ_ADDR;
        if (bus.memreq_rdy) state_n = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        bus.memresp_rdy = 1'b1;
        memresp_en      = 1'b1;
        if (bus.memresp_val) state_n = REFILL_UPDATE;
      end
      REFILL_UPDATE: begin
        tag_array_wen      = 1'b1;
        data_array_wen     = 1'b1;
        data_array_wben    = '1;
        write_data_mux_sel = MEM_LINE;
        valid_wen          = 1'b1;
        valid_wdata        = 1'b1;
        dirty_wen          = 1'b1;
        state_n            = (type_q == TYPE_WRITE) ? WRITE_ACCESS : READ_ACCESS;
      end
      WAIT: begin
        bus.cacheresp_val  = 1'b1;
        bus.cacheresp_type = type_q;
        if (resp_has_data) read_word_mux_sel = word_sel;
        if (bus.cacheresp_rdy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_blocking_cache_wb_ctrl.sv
// Directed bench for blocking_cache_wb_ctrl: default 16x4 instance plus a 32x8
// instance fed the same stimulus for the wide-line byte-enable and word-select cases.
module tb_blocking_cache_wb_ctrl;
  import blocking_cache_wb_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tag_match = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  blocking_cache_wb_ctrl_if busa ();
  blocking_cache_wb_ctrl_if busb ();

  assign busb.cachereq_val  = busa.cachereq_val;
  assign busb.cachereq_type = busa.cachereq_type;
  assign busb.cachereq_addr = busa.cachereq_addr;
  assign busb.cacheresp_rdy = busa.cacheresp_rdy;
  assign busb.memreq_rdy    = busa.memreq_rdy;
  assign busb.memresp_val   = busa.memresp_val;

  logic        a_cachereq_en, a_memresp_en, a_evict_en, a_rdreg_en;
  logic        a_tag_ren, a_tag_wen, a_data_ren, a_data_wen;
  logic [15:0] a_wben;
  logic        a_wdata_sel, a_maddr_sel;
  logic [2:0]  a_rsel;

  logic        b_cachereq_en, b_memresp_en, b_evict_en, b_rdreg_en;
  logic        b_tag_ren, b_tag_wen, b_data_ren, b_data_wen;
  logic [31:0] b_wben;
  logic        b_wdata_sel, b_maddr_sel;
  logic [3:0]  b_rsel;

  blocking_cache_wb_ctrl #(.p_num_blocks(16), .p_line_words(4), .p_idx_shamt(0)) dut_a (
    .clk (clk), .reset (reset), .bus (busa), .tag_match (tag_match),
    .cachereq_en (a_cachereq_en), .memresp_en (a_memresp_en),
    .evict_addr_reg_en (a_evict_en), .read_data_reg_en (a_rdreg_en),
    .tag_array_ren (a_tag_ren), .tag_array_wen (a_tag_wen),
    .data_array_ren (a_data_ren), .data_array_wen (a_data_wen),
    .data_array_wben (a_wben), .write_data_mux_sel (a_wdata_sel),
    .memreq_addr_mux_sel (a_maddr_sel), .read_word_mux_sel (a_rsel)
  );

  blocking_cache_wb_ctrl #(.p_num_blocks(32), .p_line_words(8), .p_idx_shamt(0)) dut_b (
    .clk (clk), .reset (reset), .bus (busb), .tag_match (tag_match),
    .cachereq_en (b_cachereq_en), .memresp_en (b_memresp_en),
    .evict_addr_reg_en (b_evict_en), .read_data_reg_en (b_rdreg_en),
    .tag_array_ren (b_tag_ren), .tag_array_wen (b_tag_wen),
    .data_array_ren (b_data_ren), .data_array_wen (b_data_wen),
    .data_array_wben (b_wben), .write_data_mux_sel (b_wdata_sel),
    .memreq_addr_mux_sel (b_maddr_sel), .read_word_mux_sel (b_rsel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one request in IDLE; returns one cycle later with the DUT in TAG_CHECK.
  task automatic send(input logic [2:0] t, input logic [31:0] a);
    check("accept_rdy", 32'(busa.cachereq_rdy), 32'd1);
    busa.cachereq_val  = 1'b1;
    busa.cachereq_type = t;
    busa.cachereq_addr = a;
    step();
    busa.cachereq_val = 1'b0;
  endtask

  initial begin
    busa.cachereq_val  = 1'b0;
    busa.cachereq_type = 3'd0;
    busa.cachereq_addr = 32'h0;
    busa.cacheresp_rdy = 1'b1;
    busa.memreq_rdy    = 1'b1;
    busa.memresp_val   = 1'b0;
    repeat (2) step();

    // Reset values
    check("rst_cachereq_rdy", 32'(busa.cachereq_rdy), 32'd1);
    check("rst_cachereq_en",  32'(a_cachereq_en), 32'd1);
    check("rst_cacheresp_val", 32'(busa.cacheresp_val), 32'd0);
    check("rst_memreq_val",   32'(busa.memreq_val), 32'd0);
    check("rst_memresp_rdy",  32'(busa.memresp_rdy), 32'd0);
    check("rst_tag_ren",      32'(a_tag_ren), 32'd0);
    check("rst_wben",         32'(a_wben), 32'd0);
    check("rst_rsel",         32'(a_rsel), 32'd0);
    reset = 1'b0;

    // Init 0x0000: TAG_CHECK, INIT_ACCESS, then response 3 cycles after accept
    send(TYPE_INIT, 32'h0000);
    check("init_tc_tag_ren", 32'(a_tag_ren), 32'd1);
    check("init_tc_rdy",     32'(busa.cachereq_rdy), 32'd0);
    step();
    check("init_tag_wen",  32'(a_tag_wen), 32'd1);
    check("init_data_wen", 32'(a_data_wen), 32'd1);
    check("init_wben",     32'(a_wben), 32'h000F);
    check("init_wsel",     32'(a_wdata_sel), 32'd0);
    check("init_no_mem",   32'(busa.memreq_val), 32'd0);
    step();
    check("init_resp_val",  32'(busa.cacheresp_val), 32'd1);
    check("init_resp_type", 32'(busa.cacheresp_type), 32'd2);
    step();

    // Read hit 0x0000
    send(TYPE_READ, 32'h0000);
    tag_match = 1'b1;
    step();
    check("rdhit_data_ren", 32'(a_data_ren), 32'd1);
    check("rdhit_rdreg_en", 32'(a_rdreg_en), 32'd1);
    check("rdhit_rsel",     32'(a_rsel), 32'd1);
    check("rdhit_no_mem",   32'(busa.memreq_val), 32'd0);
    step();
    check("rdhit_resp_val",  32'(busa.cacheresp_val), 32'd1);
    check("rdhit_resp_type", 32'(busa.cacheresp_type), 32'd0);
    check("rdhit_resp_rsel", 32'(a_rsel), 32'd1);
    step();

    // Clean miss read 0x1004 (index 0, word 1)
    send(TYPE_READ, 32'h1004);
    tag_match = 1'b0;
    step();
    check("cm_memreq_val",  32'(busa.memreq_val), 32'd1);
    check("cm_memreq_type", 32'(busa.memreq_type), 32'd0);
    check("cm_maddr_sel",   32'(a_maddr_sel), 32'd1);
    step();
    check("cm_wait_memreq",  32'(busa.memreq_val), 32'd0);
    check("cm_memresp_rdy",  32'(busa.memresp_rdy), 32'd1);
    check("cm_memresp_en",   32'(a_memresp_en), 32'd1);
    busa.memresp_val = 1'b1;
    step();
    busa.memresp_val = 1'b0;
    check("cm_upd_tag_wen", 32'(a_tag_wen), 32'd1);
    check("cm_upd_wben",    32'(a_wben), 32'hFFFF);
    check("cm_upd_wsel",    32'(a_wdata_sel), 32'd1);
    step();
    check("cm_rd_rsel", 32'(a_rsel), 32'd2);
    step();
    check("cm_resp_val", 32'(busa.cacheresp_val), 32'd1);
    check("cm_resp_rsel", 32'(a_rsel), 32'd2);
    step();

    // Write hit 0x1008 (word 2)
    send(TYPE_WRITE, 32'h1008);
    tag_match = 1'b1;
    step();
    check("wr_data_wen", 32'(a_data_wen), 32'd1);
    check("wr_wben",     32'(a_wben), 32'h0F00);
    check("wr_wsel",     32'(a_wdata_sel), 32'd0);
    check("wr_no_mem",   32'(busa.memreq_val), 32'd0);
    step();
    check("wr_resp_type", 32'(busa.cacheresp_type), 32'd1);
    check("wr_resp_rsel", 32'(a_rsel), 32'd0);
    step();

    // Dirty miss read 0x2008: evict (memreq_rdy held low 4 cycles), then refill
    send(TYPE_READ, 32'h2008);
    tag_match = 1'b0;
    step();
    check("dm_prep_evict_en", 32'(a_evict_en), 32'd1);
    check("dm_prep_data_ren", 32'(a_data_ren), 32'd1);
    check("dm_prep_tag_ren",  32'(a_tag_ren), 32'd1);
    check("dm_prep_no_mem",   32'(busa.memreq_val), 32'd0);
    busa.memreq_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("dm_evict_val",   32'(busa.memreq_val), 32'd1);
      check("dm_evict_type",  32'(busa.memreq_type), 32'd1);
      check("dm_evict_asel",  32'(a_maddr_sel), 32'd0);
      if (i == 3) busa.memreq_rdy = 1'b1;
    end
    step();
    check("dm_ewait_memreq", 32'(busa.memreq_val), 32'd0);
    check("dm_ewait_rdy",    32'(busa.memresp_rdy), 32'd1);
    check("dm_ewait_en",     32'(a_memresp_en), 32'd0);
    busa.memresp_val = 1'b1;
    step();
    busa.memresp_val = 1'b0;
    check("dm_refill_val",  32'(busa.memreq_val), 32'd1);
    check("dm_refill_type", 32'(busa.memreq_type), 32'd0);
    check("dm_refill_asel", 32'(a_maddr_sel), 32'd1);
    step();
    busa.memresp_val = 1'b1;
    step();
    busa.memresp_val = 1'b0;
    check("dm_upd_wben", 32'(a_wben), 32'hFFFF);
    step();
    check("dm_rd_rsel", 32'(a_rsel), 32'd3);
    step();
    check("dm_resp_val", 32'(busa.cacheresp_val), 32'd1);
    step();

    // Read hit 0x2008 with cacheresp_rdy held low for 5 cycles
    busa.cacheresp_rdy = 1'b0;
    send(TYPE_READ, 32'h2008);
    tag_match = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_resp_val",     32'(busa.cacheresp_val), 32'd1);
      check("bp_cachereq_rdy", 32'(busa.cachereq_rdy), 32'd0);
      if (i == 4) busa.cacheresp_rdy = 1'b1;
    end
    step();
    check("bp_done_val", 32'(busa.cacheresp_val), 32'd0);
    check("bp_done_rdy", 32'(busa.cachereq_rdy), 32'd1);

    // Line was refilled clean: miss on 0x1008 must refill without evicting
    send(TYPE_READ, 32'h1008);
    tag_match = 1'b0;
    step();
    check("clean_no_evict_val",  32'(busa.memreq_val), 32'd1);
    check("clean_no_evict_type", 32'(busa.memreq_type), 32'd0);
    step();
    check("rw_memresp_rdy", 32'(busa.memresp_rdy), 32'd1);
    reset = 1'b1;
    step();
    check("midrst_cachereq_rdy", 32'(busa.cachereq_rdy), 32'd1);
    check("midrst_memresp_rdy",  32'(busa.memresp_rdy), 32'd0);
    check("midrst_memreq_val",   32'(busa.memreq_val), 32'd0);
    check("midrst_resp_val",     32'(busa.cacheresp_val), 32'd0);
    reset = 1'b0;

    // After reset a matching tag still misses because valid was cleared
    send(TYPE_READ, 32'h2008);
    tag_match = 1'b1;
    step();
    check("postrst_miss_val",  32'(busa.memreq_val), 32'd1);
    check("postrst_miss_type", 32'(busa.memreq_type), 32'd0);
    check("postrst_no_read",   32'(a_data_ren), 32'd0);
    step();
    busa.memresp_val = 1'b1;
    step();
    busa.memresp_val = 1'b0;
    step();
    step();
    check("postrst_resp_val", 32'(busa.cacheresp_val), 32'd1);
    step();

    // Unknown request type 3 behaves as a read and is echoed back
    send(3'd3, 32'h2008);
    tag_match = 1'b1;
    step();
    check("unk_data_ren", 32'(a_data_ren), 32'd1);
    check("unk_data_wen", 32'(a_data_wen), 32'd0);
    check("unk_rsel",     32'(a_rsel), 32'd3);
    step();
    check("unk_resp_type", 32'(busa.cacheresp_type), 32'd3);
    step();

    // 32 blocks x 8 words: write then read 0x001C (word 7)
    reset = 1'b1;
    step();
    reset = 1'b0;
    send(TYPE_WRITE, 32'h001C);
    tag_match = 1'b0;
    step();
    check("w8_cold_miss", 32'(busb.memreq_val), 32'd1);
    step();
    busa.memresp_val = 1'b1;
    step();
    busa.memresp_val = 1'b0;
    check("w8_upd_wben", b_wben, 32'hFFFF_FFFF);
    step();
    check("w8_wr_wben",     b_wben, 32'hF000_0000);
    check("w8_wr_data_wen", 32'(b_data_wen), 32'd1);
    step();
    check("w8_resp_val", 32'(busb.cacheresp_val), 32'd1);
    step();
    send(TYPE_READ, 32'h001C);
    tag_match = 1'b1;
    step();
    check("w8_rd_rsel",     32'(b_rsel), 32'd8);
    check("w8_rd_data_ren", 32'(b_data_ren), 32'd1);
    step();
    check("w8_resp_rsel", 32'(b_rsel), 32'd8);
    check("w8_resp_type", 32'(busb.cacheresp_type), 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
